// File: rtl/cpu_pkg.sv
// Shared definitions for the Group-K CPU: datapath width, reset vector and
// the program-counter sequencer state type.
package cpu_pkg;

    localparam int unsigned PC_W      = 16;
    localparam logic [15:0] RESET_VEC = 16'h0000;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_EXEC  = 2'd2,
        ST_HALT  = 2'd3
    } seqState_t;

endpackage

// File: rtl/pc_sequencer_adder_1.sv
// PC+1 incrementer shared by the sequencer; purely combinational.
module ADDER_1 #(
    parameter int unsigned W = 16
) (
    input  logic [W-1:0] a,
    output logic [W-1:0] sum
);

    assign sum = a + W'(1);

endmodule

// File: rtl/pc_sequencer.sv
// Program-counter sequencer: owns the PC, fetches through a req/ack handshake
// and applies halt/stall/jump/branch redirects while an instruction executes.
module pc_sequencer #(
    parameter int unsigned     PC_W      = cpu_pkg::PC_W,
    parameter logic [PC_W-1:0] RESET_VEC = PC_W'(cpu_pkg::RESET_VEC)
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic            imem_req_o,
    output logic [PC_W-1:0] imem_addr_o,
    input  logic            imem_ack_i,
    output logic            instr_valid_o,
    output logic [PC_W-1:0] pc_o,
    output logic [PC_W-1:0] pc_plus1_o,
    input  logic            stall_i,
    input  logic            halt_i,
    input  logic            jump_i,
    input  logic [PC_W-1:0] jump_addr_i,
    input  logic            branch_i,
    input  logic [PC_W-1:0] branch_off_i,
    output logic            flush_o,
    output logic            halted_o,
    output logic [PC_W-1:0] retired_cnt_o
);

    import cpu_pkg::*;

    seqState_t       stateQ, stateD;
    logic [PC_W-1:0] pcQ, pcD;
    logic [PC_W-1:0] retiredQ, retiredD;
    logic [PC_W-1:0] pcPlus1, branchTarget;
    logic            flushQ, flushD;

    ADDER_1 #(.W(PC_W)) uPcInc (
        .a   (pcQ),
        .sum (pcPlus1)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stateQ   <= ST_IDLE;
            pcQ      <= RESET_VEC;
            retiredQ <= '0;
            flushQ   <= 1'b0;
        end else begin
            stateQ   <= stateD;
            pcQ      <= pcD;
            retiredQ <= retiredD;
            flushQ   <= flushD;
        end
    end

    // Redirects are only looked at in EXEC; priority halt > stall > jump > branch.
    always_comb begin
        stateD       = stateQ;
        pcD          = pcQ;
        retiredD     = retiredQ;
        flushD       = 1'b0;
        branchTarget = pcPlus1 + branch_off_i;
        unique case (stateQ)
            ST_IDLE:  stateD = ST_FETCH;
            ST_FETCH: if (imem_ack_i) stateD = ST_EXEC;
            ST_EXEC: begin
                if (halt_i) begin
                    stateD   = ST_HALT;
                    retiredD = retiredQ + PC_W'(1);
                end else if (!stall_i) begin
                    stateD   = ST_FETCH;
                    retiredD = retiredQ + PC_W'(1);
                    if (jump_i) begin
                        pcD    = jump_addr_i;
                        flushD = 1'b1;
                    end else if (branch_i) begin
                        pcD    = branchTarget;
                        flushD = 1'b1;
                    end else begin
                        pcD = pcPlus1;
                    end
                end
            end
            ST_HALT:  stateD = ST_HALT;
        endcase
    end

    always_comb begin
        imem_req_o    = (stateQ == ST_FETCH);
        instr_valid_o = (stateQ == ST_EXEC);
        halted_o      = (stateQ == ST_HALT);
    end

    assign imem_addr_o   = pcQ;
    assign pc_o          = pcQ;
    assign pc_plus1_o    = pcPlus1;
    assign flush_o       = flushQ;
    assign retired_cnt_o = retiredQ;

endmodule
